// File: rtl/sitcpxg_rx_pkg.sv
// Shared constants, clear-FSM states and lane arithmetic for the SiTCP 10GbE RX buffer reader.
package sitcpxg_rx_pkg;

  localparam int unsigned ADDR_W_MIN = 13;
  localparam int unsigned ADDR_W_MAX = 16;
  localparam int unsigned LANES      = 8;

  typedef enum logic {
    ST_RUN,
    ST_CLR
  } clr_state_e;

  // Lane index of the lowest set enable bit; WENB[0] is the last byte of the word.
  function automatic logic [2:0] lsb_index(input logic [7:0] enb);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (enb[LANES-1-i]) idx = 3'(LANES-1-i);
    end
    return idx;
  endfunction

  // Bytes in one beat: up to the end of the current word, limited by what is stored.
  function automatic logic [3:0] beat_len(input logic [2:0] off, input logic [15:0] avail);
    logic [3:0] room;
    room = 4'(LANES) - {1'b0, off};
    return (avail < {12'b0, room}) ? avail[3:0] : room;
  endfunction

endpackage

// File: rtl/sitcpxg_rx_buffer_reader_if.sv
// SiTCP RX write/return signals plus the user-side byte stream, bundled for the buffer reader.
interface sitcpxg_rx_buffer_reader_if #(
  parameter int unsigned ADDR_W = 13
);
  logic [15:0]     USER_RX_SIZE;
  logic            USER_RX_CLR_ENB;
  logic            USER_RX_CLR_REQ;
  logic [15:0]     USER_RX_RADR;
  logic [15:0]     USER_RX_WADR;
  logic [7:0]      USER_RX_WENB;
  logic [63:0]     USER_RX_WDAT;
  logic [63:0]     OUT_D;
  logic [3:0]      OUT_B;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [ADDR_W:0] FILL;

  modport slave (
    output USER_RX_SIZE, USER_RX_CLR_REQ, USER_RX_RADR, OUT_D, OUT_B, OUT_VALID, FILL,
    input  USER_RX_CLR_ENB, USER_RX_WADR, USER_RX_WENB, USER_RX_WDAT, OUT_READY
  );

  modport master (
    input  USER_RX_SIZE, USER_RX_CLR_REQ, USER_RX_RADR, OUT_D, OUT_B, OUT_VALID, FILL,
    output USER_RX_CLR_ENB, USER_RX_WADR, USER_RX_WENB, USER_RX_WDAT, OUT_READY
  );
endinterface

// File: rtl/sitcpxg_rx_ram.sv
// Simple dual-port 64-bit RAM with eight byte-write lanes and a registered read (read-first).
module sitcpxg_rx_ram
  import sitcpxg_rx_pkg::*;
#(
  parameter int unsigned WORD_AW = 10
) (
  input  logic               clk,
  input  logic [WORD_AW-1:0] i_waddr,
  input  logic [7:0]         i_wenb,
  input  logic [63:0]        i_wdata,
  input  logic               i_ren,
  input  logic [WORD_AW-1:0] i_raddr,
  output logic [63:0]        o_rdata
);
  logic [63:0] r_mem [2**WORD_AW];
  logic [63:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i_wenb[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (i_ren) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/sitcpxg_rx_buffer_reader.sv
// Consumer end of the SiTCP 10GbE RX buffer: stores SiTCP writes and drains them as
// left-justified valid/ready beats, returning the consumed-byte pointer and clear handshake.
module sitcpxg_rx_buffer_reader
  import sitcpxg_rx_pkg::*;
#(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned RX_SIZE = 8176
) (
  input logic                       XGMII_CLOCK,
  input logic                       RSTn,
  sitcpxg_rx_buffer_reader_if.slave bus
);
  localparam int unsigned WORD_AW = ADDR_W - 3;
  typedef logic [ADDR_W-1:0] ptr_t;

  clr_state_e  r_state, w_state_nxt;
  ptr_t        r_wr_end, r_rd_ptr, r_acc_ptr;
  logic        r_infl;
  logic [2:0]  r_infl_off;
  logic [3:0]  r_infl_n;
  logic [63:0] r_fd [2];
  logic [3:0]  r_fb [2];
  logic        r_fwp, r_frp;
  logic [1:0]  r_fcnt;

  logic        w_clr_go, w_wr, w_issue, w_valid, w_pop, w_unused_wadr;
  logic [7:0]  w_ram_wenb;
  logic [2:0]  w_lsb;
  logic [3:0]  w_n;
  logic [1:0]  w_held;
  ptr_t        w_wr_end_nxt, w_avail;
  logic [63:0] w_rdata, w_shift, w_align;

  always_comb begin
    w_state_nxt = r_state;
    w_clr_go    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.USER_RX_CLR_ENB && (r_wr_end != '0 || r_acc_ptr != '0 || w_valid)) begin
          w_state_nxt = ST_CLR;
          w_clr_go    = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_valid      = (r_fcnt != 2'd0);
  assign w_pop        = w_valid && bus.OUT_READY;
  assign w_wr         = (bus.USER_RX_WENB != '0) && (r_state == ST_RUN) && !w_clr_go;
  assign w_ram_wenb   = w_wr ? bus.USER_RX_WENB : '0;
  assign w_lsb        = lsb_index(bus.USER_RX_WENB);
  assign w_wr_end_nxt = {bus.USER_RX_WADR[ADDR_W-1:3], 3'b000} + ptr_t'(4'd8 - {1'b0, w_lsb});
  assign w_avail      = r_wr_end - r_rd_ptr;
  assign w_n          = beat_len(r_rd_ptr[2:0], 16'(w_avail));
  assign w_unused_wadr = ^bus.USER_RX_WADR;

  // Occupancy counts the beat leaving this cycle, so a full FIFO still refills at 1 beat/cycle.
  assign w_held  = r_fcnt + {1'b0, r_infl} - {1'b0, w_pop};
  assign w_issue = (r_state == ST_RUN) && !w_clr_go && (r_rd_ptr != r_wr_end) && (w_held < 2'd2);

  sitcpxg_rx_ram #(.WORD_AW(WORD_AW)) u_ram (
    .clk     (XGMII_CLOCK),
    .i_waddr (bus.USER_RX_WADR[ADDR_W-1:3]),
    .i_wenb  (w_ram_wenb),
    .i_wdata (bus.USER_RX_WDAT),
    .i_ren   (w_issue),
    .i_raddr (r_rd_ptr[ADDR_W-1:3]),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_shift = w_rdata << {r_infl_off, 3'b000};
    w_align = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i < 32'(r_infl_n)) w_align[63-8*i -: 8] = w_shift[63-8*i -: 8];
    end
  end

  always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= ST_RUN;
      r_wr_end   <= '0;
      r_rd_ptr   <= '0;
      r_acc_ptr  <= '0;
      r_infl     <= 1'b0;
      r_infl_off <= '0;
      r_infl_n   <= '0;
      r_fwp      <= 1'b0;
      r_frp      <= 1'b0;
      r_fcnt     <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_fd[i] <= '0;
        r_fb[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      // Entering CLR drops everything at once so the CLR cycle already shows an empty buffer.
      if (w_clr_go) begin
        r_wr_end  <= '0;
        r_rd_ptr  <= '0;
        r_acc_ptr <= '0;
        r_infl    <= 1'b0;
        r_fwp     <= 1'b0;
        r_frp     <= 1'b0;
        r_fcnt    <= '0;
      end else begin
        if (w_wr) r_wr_end <= w_wr_end_nxt;
        r_infl <= w_issue;
        if (w_issue) begin
          r_rd_ptr   <= r_rd_ptr + ptr_t'(w_n);
          r_infl_off <= r_rd_ptr[2:0];
          r_infl_n   <= w_n;
        end
        if (r_infl) begin
          r_fd[r_fwp] <= w_align;
          r_fb[r_fwp] <= r_infl_n;
          r_fwp       <= ~r_fwp;
        end
        if (w_pop) begin
          r_acc_ptr <= r_acc_ptr + ptr_t'(r_fb[r_frp]);
          r_frp     <= ~r_frp;
        end
        r_fcnt <= r_fcnt + {1'b0, r_infl} - {1'b0, w_pop};
      end
    end
  end

  assign bus.USER_RX_SIZE    = 16'(RX_SIZE);
  assign bus.USER_RX_CLR_REQ = (r_state == ST_CLR);
  assign bus.USER_RX_RADR    = 16'(r_acc_ptr);
  assign bus.OUT_VALID       = w_valid;
  assign bus.OUT_D           = w_valid ? r_fd[r_frp] : '0;
  assign bus.OUT_B           = w_valid ? r_fb[r_frp] : '0;
  assign bus.FILL            = {1'b0, r_wr_end - r_acc_ptr};
endmodule
